// File: rtl/fft_frame_sink_if.sv
// fft_frame_sink_if: input sample stream plus valid/ready frame replay bus
interface fft_frame_sink_if #(
  parameter int TOTAL_STEP = 6,
  parameter int DATA_WIDTH = 16
);
  logic ien;
  logic [DATA_WIDTH-1:0] iReal;
  logic [DATA_WIDTH-1:0] iImag;
  logic oen;
  logic ordy;
  logic [DATA_WIDTH-1:0] oReal;
  logic [DATA_WIDTH-1:0] oImag;
  logic [TOTAL_STEP-1:0] oIdx;
  logic olast;
  logic frame_done;
  logic ovf;
  modport master (
    output ien, iReal, iImag, ordy,
    input  oen, oReal, oImag, oIdx, olast, frame_done, ovf
  );
  modport slave (
    input  ien, iReal, iImag, ordy,
    output oen, oReal, oImag, oIdx, olast, frame_done, ovf
  );
endinterface

// File: rtl/fft_frame_sink.sv
// fft_frame_sink: ping-pong frame collector with optional bit-reverse reorder and valid/ready replay
module fft_frame_sink #(
  parameter int TOTAL_STEP = 6,
  parameter int DATA_WIDTH = 16,
  parameter bit BITREV = 1
) (
  input logic iclk,
  input logic rst,
  fft_frame_sink_if.slave bus
);
  localparam int N = 1 << TOTAL_STEP;
  localparam int W = 2 * DATA_WIDTH;
  logic [W-1:0] mem [2][N];
  logic [W-1:0] rd;
  logic [1:0] full;
  logic wsel, rsel, drop, dropping, wend, commit, commit_d, load, rend;
  logic [TOTAL_STEP-1:0] wcnt, rcnt, rev, waddr;
  for (genvar i = 0; i < TOTAL_STEP; i++) begin : g_rev
    assign rev[i] = wcnt[TOTAL_STEP-1-i];
  end
  assign waddr = BITREV ? rev : wcnt;
  assign dropping = (wcnt == '0) ? full[wsel] : drop;
  assign wend = bus.ien && (&wcnt);
  assign commit = wend && !dropping;
  assign load = (!bus.oen || bus.ordy) && full[rsel];
  assign rend = load && (&rcnt);
  assign rd = mem[rsel][rcnt];
  // Sample storage; a dropped frame never touches the bank being read
  always_ff @(posedge iclk)
    if (bus.ien && !dropping) mem[wsel][waddr] <= {bus.iReal, bus.iImag};
  // Write pointer: the drop decision is latched on sample 0 and held for the whole frame
  always_ff @(posedge iclk or posedge rst)
    if (rst) begin
      wsel <= 1'b0;
      wcnt <= '0;
      drop <= 1'b0;
    end else if (bus.ien) begin
      drop <= dropping;
      wcnt <= wcnt + 1'b1;
      wsel <= commit ? ~wsel : wsel;
    end
  // Bank ownership: writer sets on commit, reader clears on loading the last sample
  always_ff @(posedge iclk or posedge rst)
    if (rst) full <= '0;
    else full <= (full | (commit ? 2'b01 << wsel : 2'b00)) & ~(rend ? 2'b01 << rsel : 2'b00);
  // Status: frame_done is delayed one cycle so it coincides with the first oen of the frame
  always_ff @(posedge iclk or posedge rst)
    if (rst) begin
      commit_d <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.ovf <= 1'b0;
    end else begin
      commit_d <= commit;
      bus.frame_done <= commit_d;
      bus.ovf <= bus.ovf | (wend && dropping);
    end
  // Output register: loads when empty or being consumed, holds while stalled
  always_ff @(posedge iclk or posedge rst)
    if (rst) begin
      rsel <= 1'b0;
      rcnt <= '0;
      bus.oen <= 1'b0;
      bus.olast <= 1'b0;
      bus.oIdx <= '0;
      bus.oReal <= '0;
      bus.oImag <= '0;
    end else if (load) begin
      bus.oReal <= rd[W-1:DATA_WIDTH];
      bus.oImag <= rd[DATA_WIDTH-1:0];
      bus.oIdx <= rcnt;
      bus.olast <= &rcnt;
      bus.oen <= 1'b1;
      rcnt <= rcnt + 1'b1;
      rsel <= rend ? ~rsel : rsel;
    end else if (bus.ordy) bus.oen <= 1'b0;
endmodule
